// File: rtl/main_mem_harness_if.sv
// Bundle of every non-clock signal between the harness, its load/readback streams and the
// mergesort core's slave RAM port.
interface main_mem_harness_if #(
    parameter int unsigned ADDR_W = 7,
    parameter int unsigned DATA_W = 8
);
    logic                       run_req;
    logic                       in_valid;
    logic [ADDR_W+DATA_W-1:0]   in_data;
    logic                       in_last;
    logic                       in_ready;
    logic                       start_port;
    logic                       done_port;
    logic [1:0]                 S_oe_ram;
    logic [1:0]                 S_we_ram;
    logic [2*ADDR_W-1:0]        S_addr_ram;
    logic [2*DATA_W-1:0]        S_Wdata_ram;
    logic [7:0]                 S_data_ram_size;
    logic [2*DATA_W-1:0]        Sout_Rdata_ram;
    logic [1:0]                 Sout_DataRdy;
    logic                       out_valid;
    logic [DATA_W-1:0]          out_data;
    logic                       out_last;
    logic                       out_ready;
    logic [31:0]                cycle_count;
    logic                       timed_out;
    logic                       busy;

    // Harness side.
    modport master (
        input  run_req, in_valid, in_data, in_last, done_port, Sout_Rdata_ram, Sout_DataRdy,
               out_ready,
        output in_ready, start_port, S_oe_ram, S_we_ram, S_addr_ram, S_Wdata_ram,
               S_data_ram_size, out_valid, out_data, out_last, cycle_count, timed_out, busy
    );

    // Environment side: streams, core and memory.
    modport slave (
        output run_req, in_valid, in_data, in_last, done_port, Sout_Rdata_ram, Sout_DataRdy,
               out_ready,
        input  in_ready, start_port, S_oe_ram, S_we_ram, S_addr_ram, S_Wdata_ram,
               S_data_ram_size, out_valid, out_data, out_last, cycle_count, timed_out, busy
    );
endinterface

// File: rtl/main_mem_harness.sv
// Preloads the mergesort core's memory over its slave port, starts it, times the run and
// streams a fixed result region back out.
module main_mem_harness #(
    parameter int unsigned ADDR_W  = 7,
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned RD_BASE = 64,
    parameter int unsigned RD_LEN  = 32,
    parameter int unsigned TIMEOUT = 200000000
) (
    input logic              clock,
    input logic              reset,
    main_mem_harness_if.master bus
);
    localparam int unsigned IdxW = $clog2(RD_LEN) + 1;
    localparam logic [ADDR_W-1:0] RdBase = ADDR_W'(RD_BASE);
    localparam logic [IdxW-1:0]   RdLastIdx = IdxW'(RD_LEN - 1);

    typedef enum logic [3:0] {
        StIdle, StLoad, StWr, StStart, StRun, StRd, StRdw, StOut, StFin
    } state_t;

    state_t              state_q;
    logic                we_q;
    logic                oe_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic                last_q;
    logic [IdxW-1:0]     rd_idx_q;
    logic                start_q;
    logic                out_valid_q;
    logic [DATA_W-1:0]   out_data_q;
    logic                out_last_q;
    logic [31:0]         cycle_count_q;
    logic                timed_out_q;
    logic [ADDR_W-1:0]   rd_addr;

    // Readback address wraps naturally at 2^ADDR_W.
    assign rd_addr = RdBase + ADDR_W'(rd_idx_q);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= StIdle;
            we_q          <= 1'b0;
            oe_q          <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            last_q        <= 1'b0;
            rd_idx_q      <= '0;
            start_q       <= 1'b0;
            out_valid_q   <= 1'b0;
            out_data_q    <= '0;
            out_last_q    <= 1'b0;
            cycle_count_q <= '0;
            timed_out_q   <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (bus.run_req) begin
                        timed_out_q   <= 1'b0;
                        cycle_count_q <= '0;
                        state_q       <= StLoad;
                    end
                end
                StLoad: begin
                    if (bus.in_valid) begin
                        addr_q  <= bus.in_data[ADDR_W+DATA_W-1:DATA_W];
                        wdata_q <= bus.in_data[DATA_W-1:0];
                        last_q  <= bus.in_last;
                        we_q    <= 1'b1;
                        state_q <= StWr;
                    end
                end
                StWr: begin
                    if (bus.Sout_DataRdy[0]) begin
                        we_q <= 1'b0;
                        if (last_q) begin
                            start_q       <= 1'b1;
                            cycle_count_q <= 32'd1;
                            state_q       <= StStart;
                        end else begin
                            state_q <= StLoad;
                        end
                    end
                end
                StStart: begin
                    start_q       <= 1'b0;
                    cycle_count_q <= cycle_count_q + 32'd1;
                    state_q       <= StRun;
                end
                StRun: begin
                    // The displayed count already includes the cycle done is sampled in.
                    if (bus.done_port) begin
                        rd_idx_q <= '0;
                        state_q  <= StRd;
                    end else if (cycle_count_q >= TIMEOUT) begin
                        timed_out_q <= 1'b1;
                        state_q     <= StFin;
                    end else if (cycle_count_q != '1) begin
                        cycle_count_q <= cycle_count_q + 32'd1;
                    end
                end
                StRd: begin
                    oe_q    <= 1'b1;
                    addr_q  <= rd_addr;
                    state_q <= StRdw;
                end
                StRdw: begin
                    if (bus.Sout_DataRdy[0]) begin
                        oe_q        <= 1'b0;
                        out_data_q  <= bus.Sout_Rdata_ram[DATA_W-1:0];
                        out_valid_q <= 1'b1;
                        out_last_q  <= (rd_idx_q == RdLastIdx);
                        state_q     <= StOut;
                    end
                end
                StOut: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        out_last_q  <= 1'b0;
                        if (out_last_q) begin
                            state_q <= StFin;
                        end else begin
                            rd_idx_q <= rd_idx_q + 1'b1;
                            state_q  <= StRd;
                        end
                    end
                end
                StFin:   state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.in_ready        = (state_q == StLoad);
    assign bus.busy            = (state_q != StIdle) && (state_q != StFin);
    assign bus.start_port      = start_q;
    assign bus.S_we_ram        = {1'b0, we_q};
    assign bus.S_oe_ram        = {1'b0, oe_q};
    assign bus.S_addr_ram      = {{ADDR_W{1'b0}}, addr_q};
    assign bus.S_Wdata_ram     = {{DATA_W{1'b0}}, wdata_q};
    assign bus.S_data_ram_size = {4'd0, (we_q || oe_q) ? 4'd8 : 4'd0};
    assign bus.out_valid       = out_valid_q;
    assign bus.out_data        = out_data_q;
    assign bus.out_last        = out_last_q;
    assign bus.cycle_count     = cycle_count_q;
    assign bus.timed_out       = timed_out_q;
endmodule

// File: tb/tb_main_mem_harness.sv
// Randomized bench for main_mem_harness: a memory responder with random latency and a
// reference memory image predict every write, readback byte, address and run count.
module tb_main_mem_harness;
    localparam int unsigned AW = 7;
    localparam int unsigned DW = 8;
    localparam int unsigned RB = 126;
    localparam int unsigned RL = 4;
    localparam int unsigned TO = 50;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    main_mem_harness_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    main_mem_harness #(
        .ADDR_W(AW), .DATA_W(DW), .RD_BASE(RB), .RD_LEN(RL), .TIMEOUT(TO)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    int vectors = 0;
    int miscompares = 0;

    logic [7:0]  ram     [128];
    logic [7:0]  exp_mem [128];
    logic [14:0] wr_q[$];
    int          rd_addrs[$];
    int          start_cnt = 0;
    int          oe_cnt = 0;
    bit          stall = 1'b0;
    bit          pend = 1'b0;
    int          lat = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Memory responder: random latency 0..3, DataRdy noise while no access is pending.
    always @(negedge clock) begin
        check("unused_channel_fields",
              32'({bus.S_oe_ram[1], bus.S_we_ram[1], bus.S_addr_ram[13:7],
                   bus.S_Wdata_ram[15:8], bus.S_data_ram_size}),
              32'({17'd0, ((bus.S_we_ram[0] || bus.S_oe_ram[0]) ? 8'd8 : 8'd0)}));
        if (bus.start_port) start_cnt++;
        if (!reset && (bus.S_we_ram[0] || bus.S_oe_ram[0])) begin
            if (!pend) begin
                pend = 1'b1;
                lat  = $urandom_range(0, 3);
            end
            if (lat == 0 && !stall) begin
                bus.Sout_DataRdy   = {1'($urandom), 1'b1};
                bus.Sout_Rdata_ram = {8'($urandom), ram[bus.S_addr_ram[6:0]]};
                if (bus.S_we_ram[0]) begin
                    ram[bus.S_addr_ram[6:0]] = bus.S_Wdata_ram[7:0];
                    if (wr_q.size() == 0) begin
                        check("unexpected_write", 32'(bus.S_we_ram), 32'd0);
                    end else begin
                        check("write_beat", 32'({bus.S_addr_ram[6:0], bus.S_Wdata_ram[7:0]}),
                              32'(wr_q.pop_front()));
                    end
                end else begin
                    rd_addrs.push_back(int'(bus.S_addr_ram[6:0]));
                    oe_cnt++;
                end
            end else begin
                bus.Sout_DataRdy   = {1'($urandom), 1'b0};
                bus.Sout_Rdata_ram = 16'($urandom);
                if (lat > 0) lat--;
            end
        end else begin
            pend = 1'b0;
            bus.Sout_DataRdy   = 2'($urandom);
            bus.Sout_Rdata_ram = 16'($urandom);
        end
    end

    task automatic session(input int nbeats, input int d, input bit poke_run);
        int   w;
        int   got;
        int   dd;
        bit   timeout;
        bit   stalled;
        logic [7:0] prev;
        rd_addrs.delete();
        start_cnt = 0;
        oe_cnt    = 0;
        timeout   = (d >= int'(TO));
        bus.run_req = 1'b1;
        @(negedge clock);
        bus.run_req = 1'b0;
        check("busy_after_req", 32'(bus.busy), 32'd1);
        check("count_cleared", bus.cycle_count, 32'd0);
        for (int b = 0; b < nbeats; b++) begin
            logic [6:0] a;
            logic [7:0] v;
            a = ($urandom % 2 == 1) ? 7'(RB + $urandom_range(0, RL - 1)) : 7'($urandom);
            v = 8'($urandom);
            bus.in_valid = 1'b1;
            bus.in_data  = {a, v};
            bus.in_last  = (b == nbeats - 1);
            w = 0;
            while (!bus.in_ready && w < 50) begin
                @(negedge clock);
                w++;
            end
            check("in_ready_load", 32'(bus.in_ready), 32'd1);
            wr_q.push_back({a, v});
            exp_mem[a] = v;
            @(negedge clock);
            bus.in_valid = 1'b0;
            bus.in_last  = 1'b0;
            check("in_ready_wr", 32'(bus.in_ready), 32'd0);
            repeat ($urandom_range(0, 2)) @(negedge clock);
        end
        w = 0;
        while (!bus.start_port && w < 100) begin
            @(negedge clock);
            w++;
        end
        check("start_seen", 32'(bus.start_port), 32'd1);
        check("count_at_start", bus.cycle_count, 32'd1);
        check("writes_drained", 32'(wr_q.size()), 32'd0);
        dd = timeout ? int'(TO) - 1 : d;
        for (int c = 1; c <= dd; c++) begin
            @(negedge clock);
            bus.run_req = poke_run && (c == 2);
            check("count_running", bus.cycle_count, 32'(c + 1));
        end
        bus.run_req = 1'b0;
        if (timeout) begin
            @(negedge clock);
            check("timeout_flag", 32'(bus.timed_out), 32'd1);
            check("timeout_count", bus.cycle_count, 32'(TO));
            check("timeout_busy", 32'(bus.busy), 32'd0);
            @(negedge clock);
            check("idle_count_hold", bus.cycle_count, 32'(TO));
            check("idle_timed_out_hold", 32'(bus.timed_out), 32'd1);
            check("timeout_no_reads", 32'(oe_cnt), 32'd0);
        end else begin
            bus.done_port = 1'b1;
            @(negedge clock);
            bus.done_port = 1'b0;
            got = 0;
            w = 0;
            stalled = 1'b0;
            prev = '0;
            bus.out_ready = 1'($urandom);
            while (got < int'(RL) && w < 400) begin
                if (bus.out_valid) begin
                    if (stalled) check("out_stable", 32'(bus.out_data), 32'(prev));
                    if (bus.out_ready) begin
                        check("out_data", 32'(bus.out_data), 32'(exp_mem[7'(RB + got)]));
                        check("out_last", 32'(bus.out_last), 32'(got == int'(RL) - 1));
                        got++;
                        stalled = 1'b0;
                    end else begin
                        stalled = 1'b1;
                        prev = bus.out_data;
                    end
                end
                @(negedge clock);
                w++;
                bus.out_ready = 1'($urandom);
            end
            bus.out_ready = 1'b0;
            check("bytes_out", 32'(got), 32'(RL));
            check("read_count", 32'(rd_addrs.size()), 32'(RL));
            for (int i = 0; i < rd_addrs.size(); i++) begin
                check("read_addr", 32'(rd_addrs[i]), 32'((RB + i) % 128));
            end
            check("fin_busy", 32'(bus.busy), 32'd0);
            check("fin_valid", 32'(bus.out_valid), 32'd0);
            check("run_count", bus.cycle_count, 32'(d + 1));
            check("no_timeout", 32'(bus.timed_out), 32'd0);
            @(negedge clock);
            check("idle_count_hold", bus.cycle_count, 32'(d + 1));
        end
        check("idle_busy", 32'(bus.busy), 32'd0);
        check("idle_in_ready", 32'(bus.in_ready), 32'd0);
        check("start_pulses", 32'(start_cnt), 32'd1);
    endtask

    initial begin
        for (int i = 0; i < 128; i++) begin
            ram[i]     = 8'($urandom);
            exp_mem[i] = ram[i];
        end
        bus.run_req   = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_last   = 1'b0;
        bus.done_port = 1'b0;
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clock);
        check("rst_outputs",
              32'({bus.in_ready, bus.start_port, bus.busy, bus.out_valid, bus.out_last,
                   bus.timed_out, bus.S_we_ram, bus.S_oe_ram, bus.out_data}),
              32'd0);
        check("rst_count", bus.cycle_count, 32'd0);
        reset = 1'b0;
        @(negedge clock);

        session(1, 10, 1'b0);
        session(3, 5, 1'b1);
        session(2, 60, 1'b0);
        session(4, 49, 1'b0);
        session(2, 50, 1'b1);

        // Reset while a write is held pending.
        stall = 1'b1;
        bus.run_req = 1'b1;
        @(negedge clock);
        bus.run_req  = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = {7'h05, 8'hA7};
        bus.in_last  = 1'b1;
        @(negedge clock);
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        check("we_before_reset", 32'(bus.S_we_ram), 32'd1);
        @(negedge clock);
        check("we_held", 32'({bus.S_we_ram, bus.S_addr_ram, bus.S_Wdata_ram}),
              32'({2'b01, 14'h0005, 16'h00A7}));
        #2 reset = 1'b1;
        #1;
        check("mid_reset_bus",
              32'({bus.S_we_ram, bus.S_oe_ram, bus.start_port, bus.busy, bus.S_data_ram_size}),
              32'd0);
        check("mid_reset_addr_data", 32'({bus.S_addr_ram, bus.S_Wdata_ram}), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        stall = 1'b0;
        @(negedge clock);

        for (int s = 0; s < 8; s++) begin
            session($urandom_range(1, 5), $urandom_range(1, 60), 1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
